seq_pattern_gen: RTL

//   Serial bit-pattern transmitter: the generating end of the serial bitstream that the Moore

---
 rtl/seq_pkg.sv | 13 +
 rtl/seq_piso.sv | 27 ++
 rtl/seq_pattern_gen.sv | 113 +++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and default pattern for pattern generator and detectors
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_GAP   = 3'd2,
        S_DONE  = 3'd3
    } seq_state_e;

    localparam logic [3:0] DEFAULT_PAT = 4'b1010;

endpackage

// File: rtl/seq_piso.sv
// rtl/seq_piso.sv - parallel-in serial-out shifter, MSB presented first
module seq_piso #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] din,
    output logic             msb
);

    logic [PAT_W-1:0] sh_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q <= '0;
        end else if (load) begin
            sh_q <= din;
        end else if (shift) begin
            sh_q <= {sh_q[PAT_W-2:0], 1'b0};
        end
    end

    assign msb = sh_q[PAT_W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial pattern transmitter, (repeat_cnt+1) MSB-first copies per start
// Optional SEQ_GEN_GAP_EN inserts a one-cycle idle bit between repetitions.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int               IDX_W    = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

    seq_state_e       state_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] rep_q;
    logic [PAT_W-1:0] pat_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    logic             accept;
    logic             reload;
    logic             msb;
    logic [PAT_W-1:0] din;

    // The shifter reloads on the same edge that ends a repetition, so the next copy has no bubble.
    assign accept = (state_q == S_IDLE) && start;
    assign reload = (state_q == S_SHIFT) && (idx_q == '0) && (rep_q != '0);
    assign din    = accept ? pattern : pat_q;

    seq_piso #(.PAT_W(PAT_W)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (accept || reload),
        .shift ((state_q == S_SHIFT) && !reload),
        .din   (din),
        .msb   (msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rep_q   <= '0;
            pat_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pat_q   <= pattern;
                        idx_q   <= IDX_LAST;
                        rep_q   <= repeat_cnt;
                        state_q <= S_SHIFT;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (idx_q == '0) begin
                        if (rep_q == '0) begin
                            state_q <= S_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            rep_q <= rep_q - 1'b1;
                            idx_q <= IDX_LAST;
`ifdef SEQ_GEN_GAP_EN
                            state_q <= S_GAP;
                            valid_q <= 1'b0;
`endif
                        end
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                S_GAP: begin
                    state_q <= S_SHIFT;
                    valid_q <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out       = msb & valid_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
